// File: rtl/kmarb_pkg.sv
// Shared types and constants for the keymap access arbiter.
package kmarb_pkg;

  localparam int KEYMAP_AW = 11;
  localparam int EVT_W     = 12;

  // Field offsets inside a packed scan event.
  localparam int EVT_SCAN_LSB = 0;
  localparam int EVT_REL_BIT  = 11;

  typedef struct packed {
    logic       released;
    logic [2:0] modifiers;
    logic       extended;
    logic [6:0] scan;
  } scan_evt_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KEYRD   = 3'd1,
    ST_KEYOUT  = 3'd2,
    ST_CPUACC  = 3'd3,
    ST_CPURD   = 3'd4,
    ST_CPUWAIT = 3'd5
  } state_t;

endpackage

// File: rtl/kmarb_event_fifo.sv
// Synchronous show-ahead FIFO for scan events. A push while full is dropped
// unless a pop happens in the same cycle, in which case both are honoured.
module kmarb_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/keymap_access_arbiter.sv
// Shares the two keymap RAMs between PS/2 scan lookups and the CPU keymap port.
// Optional build macro KMARB_DROP_COUNT_EN adds a saturating drop_count output.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | arbitrate: rewind, CPU access, or pop a scan event
// ST_KEYRD   | keymap address presented, waiting for RAM read data
// ST_KEYOUT  | RAM data valid, capture key outputs
// ST_CPUACC  | CPU address on the RAM; write strobe issued here
// ST_CPURD   | capture CPU read data
// ST_CPUWAIT | access done, wait for CPU to drop its request
module keymap_access_arbiter
  import kmarb_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_KEY_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scan_received,
  input  logic [6:0]           scan,
  input  logic                 extended,
  input  logic                 released,
  input  logic [2:0]           modifiers,
  output logic                 key_valid,
  output logic                 key_released,
  output logic [2:0]           keyrow1,
  output logic [4:0]           keycol1,
  output logic [2:0]           keyrow2,
  output logic [4:0]           keycol2,
  input  logic                 cpuread,
  input  logic                 cpuwrite,
  input  logic                 rewind,
  input  logic [7:0]           din,
  output logic [7:0]           dout,
  output logic                 cpu_done,
  output logic [KEYMAP_AW-1:0] ram_addr,
  output logic                 ram_we1,
  output logic                 ram_we2,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata1,
  input  logic [7:0]           ram_rdata2,
  output logic                 fifo_full
`ifdef KMARB_DROP_COUNT_EN
  ,
  output logic [7:0]           drop_count
`endif
);

  localparam int BURST_W = $clog2(MAX_KEY_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_KEY_BURST);

  state_t               state_q, state_d;
  logic [11:0]          cpuaddr_q, cpuaddr_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [KEYMAP_AW-1:0] key_addr_q, key_addr_d;
  logic                 key_rel_q, key_rel_d;
  logic                 key_valid_q, key_valid_d;
  logic                 key_released_q, key_released_d;
  logic [7:0]           key1_q, key1_d;
  logic [7:0]           key2_q, key2_d;
  logic [7:0]           dout_q, dout_d;
  logic                 cpu_done_q, cpu_done_d;

  scan_evt_t            evt_in;
  logic [EVT_W-1:0]     fifo_rdata;
  logic                 fifo_pop, fifo_empty, fifo_full_w;
  logic                 cpu_req, cpu_wr_now;

  assign evt_in     = {released, modifiers, extended, scan};
  assign cpu_req    = cpuread | cpuwrite;
  assign cpu_wr_now = (state_q == ST_CPUACC) & cpuwrite;

  kmarb_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (scan_received),
    .pop   (fifo_pop),
    .wdata (evt_in),
    .rdata (fifo_rdata),
    .full  (fifo_full_w),
    .empty (fifo_empty)
  );

  // RAM address/strobes: CPU owns the bus only in ST_CPUACC, lookups otherwise.
  assign ram_addr  = (state_q == ST_CPUACC) ? cpuaddr_q[11:1] : key_addr_q;
  assign ram_we1   = cpu_wr_now & ~cpuaddr_q[0];
  assign ram_we2   = cpu_wr_now &  cpuaddr_q[0];
  assign ram_wdata = cpu_wr_now ? din : 8'h00;

  assign key_valid    = key_valid_q;
  assign key_released = key_released_q;
  assign keyrow1      = key1_q[7:5];
  assign keycol1      = key1_q[4:0];
  assign keyrow2      = key2_q[7:5];
  assign keycol2      = key2_q[4:0];
  assign dout         = dout_q;
  assign cpu_done     = cpu_done_q;
  assign fifo_full    = fifo_full_w;

  // Arbitration FSM: next state and registered outputs.
  always_comb begin
    state_d        = state_q;
    cpuaddr_d      = cpuaddr_q;
    burst_d        = burst_q;
    key_addr_d     = key_addr_q;
    key_rel_d      = key_rel_q;
    key_valid_d    = 1'b0;
    key_released_d = key_released_q;
    key1_d         = key1_q;
    key2_d         = key2_q;
    dout_d         = dout_q;
    cpu_done_d     = 1'b0;
    fifo_pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rewind) begin
          cpuaddr_d  = '0;
          cpu_done_d = 1'b1;
        end else if (cpu_req && (fifo_empty || burst_q == BURST_MAX)) begin
          burst_d = '0;
          state_d = ST_CPUACC;
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          key_addr_d = fifo_rdata[EVT_REL_BIT-1:EVT_SCAN_LSB];
          key_rel_d  = fifo_rdata[EVT_REL_BIT];
          if (!cpu_req)                burst_d = '0;
          else if (burst_q != BURST_MAX) burst_d = burst_q + BURST_W'(1);
          state_d = ST_KEYRD;
        end
      end
      ST_KEYRD: state_d = ST_KEYOUT;
      ST_KEYOUT: begin
        key1_d         = ram_rdata1;
        key2_d         = ram_rdata2;
        key_released_d = key_rel_q;
        key_valid_d    = 1'b1;
        state_d        = ST_IDLE;
      end
      ST_CPUACC: begin
        if (cpuwrite) begin
          cpu_done_d = 1'b1;
          state_d    = ST_CPUWAIT;
        end else if (cpuread) begin
          state_d = ST_CPURD;
        end else begin
          // Request withdrawn before service; no access, no address step.
          state_d = ST_IDLE;
        end
      end
      ST_CPURD: begin
        dout_d     = cpuaddr_q[0] ? ram_rdata2 : ram_rdata1;
        cpu_done_d = 1'b1;
        state_d    = ST_CPUWAIT;
      end
      ST_CPUWAIT: begin
        if (!cpu_req) begin
          cpuaddr_d = cpuaddr_q + 12'd1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cpuaddr_q      <= '0;
      burst_q        <= '0;
      key_addr_q     <= '0;
      key_rel_q      <= 1'b0;
      key_valid_q    <= 1'b0;
      key_released_q <= 1'b0;
      key1_q         <= '0;
      key2_q         <= '0;
      dout_q         <= '0;
      cpu_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cpuaddr_q      <= cpuaddr_d;
      burst_q        <= burst_d;
      key_addr_q     <= key_addr_d;
      key_rel_q      <= key_rel_d;
      key_valid_q    <= key_valid_d;
      key_released_q <= key_released_d;
      key1_q         <= key1_d;
      key2_q         <= key2_d;
      dout_q         <= dout_d;
      cpu_done_q     <= cpu_done_d;
    end
  end

`ifdef KMARB_DROP_COUNT_EN
  logic [7:0] drop_count_q, drop_count_d;
  logic       fifo_drop;

  assign fifo_drop  = scan_received & fifo_full_w & ~fifo_pop;
  assign drop_count = drop_count_q;

  // Saturating count of events lost to a full FIFO; a serviced rewind clears it.
  always_comb begin
    drop_count_d = drop_count_q;
    if (state_q == ST_IDLE && rewind)            drop_count_d = 8'h00;
    else if (fifo_drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_count_q <= 8'h00;
    else        drop_count_q <= drop_count_d;
  end
`endif

endmodule

// File: tb/tb_keymap_access_arbiter.sv
// Self-checking bench for keymap_access_arbiter with behavioural keymap RAMs.
module tb_keymap_access_arbiter;

  localparam int MAXB = 4;

  typedef struct packed {
    logic       rel;
    logic [2:0] mods;
    logic       ext;
    logic [6:0] scan;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_received, extended, released;
  logic [6:0]  scan;
  logic [2:0]  modifiers;
  logic        key_valid, key_released;
  logic [2:0]  keyrow1, keyrow2;
  logic [4:0]  keycol1, keycol2;
  logic        cpuread, cpuwrite, rewind;
  logic [7:0]  din, dout;
  logic        cpu_done;
  logic [10:0] ram_addr;
  logic        ram_we1, ram_we2;
  logic [7:0]  ram_wdata, ram_rdata1, ram_rdata2;
  logic        fifo_full;
`ifdef KMARB_DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  int          tests = 0;
  int          fails = 0;
  logic [11:0] exp_cpuaddr = '0;
  logic [7:0]  km1 [2048];
  logic [7:0]  km2 [2048];

  always #5 clk = ~clk;

  keymap_access_arbiter #(.FIFO_DEPTH(4), .MAX_KEY_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .scan_received(scan_received), .scan(scan), .extended(extended),
    .released(released), .modifiers(modifiers),
    .key_valid(key_valid), .key_released(key_released),
    .keyrow1(keyrow1), .keycol1(keycol1), .keyrow2(keyrow2), .keycol2(keycol2),
    .cpuread(cpuread), .cpuwrite(cpuwrite), .rewind(rewind), .din(din),
    .dout(dout), .cpu_done(cpu_done),
    .ram_addr(ram_addr), .ram_we1(ram_we1), .ram_we2(ram_we2),
    .ram_wdata(ram_wdata), .ram_rdata1(ram_rdata1), .ram_rdata2(ram_rdata2),
    .fifo_full(fifo_full)
`ifdef KMARB_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  // Keymap RAMs: synchronous read with one cycle of latency.
  always @(posedge clk) begin
    if (ram_we1) km1[ram_addr] <= ram_wdata;
    if (ram_we2) km2[ram_addr] <= ram_wdata;
    ram_rdata1 <= km1[ram_addr];
    ram_rdata2 <= km2[ram_addr];
  end

  // Model: lookup result {released, key1 byte, key2 byte} for an event.
  function automatic logic [16:0] exp_key(evt_t e);
    logic [10:0] a;
    a = {e.mods, e.ext, e.scan};
    return {e.rel, km1[a], km2[a]};
  endfunction

  function automatic logic [7:0] exp_cpu_byte(logic [11:0] a);
    return a[0] ? km2[a[11:1]] : km1[a[11:1]];
  endfunction

  function automatic evt_t rand_evt();
    evt_t e;
    e = 12'($urandom_range(0, 4095));
    return e;
  endfunction

  function automatic logic [16:0] got_key();
    return {key_released, keyrow1, keycol1, keyrow2, keycol2};
  endfunction

  task automatic drive_evt(input evt_t e);
    scan_received = 1'b1;
    scan          = e.scan;
    extended      = e.ext;
    released      = e.rel;
    modifiers     = e.mods;
  endtask

  task automatic do_rewind(output logic done);
    rewind = 1'b1;
    @(negedge clk);
    done   = cpu_done;
    rewind = 1'b0;
    exp_cpuaddr = '0;
  endtask

  task automatic cpu_access(input logic wr, input logic [7:0] data, output logic [7:0] rd,
                            output int n_we1, output int n_we2, output logic [10:0] waddr,
                            output logic [7:0] wdat, output logic ok);
    ok = 1'b0; rd = '0; n_we1 = 0; n_we2 = 0; waddr = '0; wdat = '0;
    cpuwrite = wr; cpuread = ~wr; din = data;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (ram_we1 || ram_we2) begin
        n_we1 += int'(ram_we1);
        n_we2 += int'(ram_we2);
        waddr = ram_addr;
        wdat  = ram_wdata;
      end
      if (cpu_done) begin
        ok = 1'b1;
        rd = dout;
      end
    end
    cpuwrite = 1'b0; cpuread = 1'b0;
    @(negedge clk);
    if (ok) exp_cpuaddr = exp_cpuaddr + 12'd1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({key_valid, key_released, keyrow1, keycol1, keyrow2, keycol2, dout, cpu_done,
         ram_addr, ram_we1, ram_we2, ram_wdata, fifo_full} !== 49'd0) begin
      fails++;
      $display("FAIL reset_outputs: got non-zero outputs, dout=%h ram_addr=%h", dout, ram_addr);
    end
`ifdef KMARB_DROP_COUNT_EN
    tests++;
    if (drop_count !== 8'h00) begin fails++; $display("FAIL reset_drop_count: got %h expected 00", drop_count); end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({key_valid, cpu_done, ram_we1, ram_we2, fifo_full} !== 5'd0) begin
      fails++;
      $display("FAIL post_reset_idle: got %b expected 00000", {key_valid, cpu_done, ram_we1, ram_we2, fifo_full});
    end
  endtask

  task automatic test_single_event();
    evt_t e;
    km1[11'h01C] = 8'h21;
    km2[11'h01C] = 8'h00;
    e = '{rel: 1'b0, mods: 3'd0, ext: 1'b0, scan: 7'h1C};
    drive_evt(e);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      scan_received = 1'b0;
      tests++;
      if (key_valid !== (k == 4)) begin
        fails++;
        $display("FAIL single_latency: cycle %0d key_valid=%b expected %b", k, key_valid, (k == 4));
      end
      if (k == 4) begin
        tests++;
        if ({keyrow1, keycol1} !== {3'd1, 5'b00001}) begin
          fails++; $display("FAIL single_key1: got %0d/%b expected 1/00001", keyrow1, keycol1);
        end
        tests++;
        if ({key_released, keyrow2, keycol2} !== 9'd0) begin
          fails++; $display("FAIL single_key2: got rel=%b %0d/%b expected 0 0/00000", key_released, keyrow2, keycol2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    evt_t q[$];
    evt_t e;
    int   sent = 0, seen = 0;
    logic full_seen = 1'b0;
    for (int cyc = 0; cyc < 60 && (sent < 5 || q.size() > 0); cyc++) begin
      @(negedge clk);
      scan_received = 1'b0;
      full_seen |= fifo_full;
      if (key_valid) begin
        seen++;
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL b2b_unexpected: got key_valid with no pending event");
        end else begin
          e = q.pop_front();
          if (got_key() !== exp_key(e)) begin
            fails++; $display("FAIL b2b_key: got %h expected %h", got_key(), exp_key(e));
          end
        end
      end
      if (sent < 5) begin
        e = rand_evt();
        drive_evt(e);
        q.push_back(e);
        sent++;
      end
    end
    tests++;
    if (seen !== 5) begin fails++; $display("FAIL b2b_count: got %0d lookups expected 5", seen); end
    tests++;
    if (full_seen !== 1'b0) begin fails++; $display("FAIL b2b_full: got fifo_full=1 expected 0"); end
  endtask

  task automatic test_random_lookups();
    evt_t q[$];
    evt_t e;
    int   sent = 0, seen = 0, gap = 0;
    for (int cyc = 0; cyc < 400 && (sent < 30 || q.size() > 0); cyc++) begin
      @(negedge clk);
      scan_received = 1'b0;
      if (key_valid) begin
        seen++;
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rand_unexpected: got key_valid with no pending event");
        end else begin
          e = q.pop_front();
          if (got_key() !== exp_key(e)) begin
            fails++; $display("FAIL rand_key: got %h expected %h", got_key(), exp_key(e));
          end
        end
      end
      if (sent < 30) begin
        if (gap == 0) begin
          e = rand_evt();
          drive_evt(e);
          q.push_back(e);
          sent++;
          gap = $urandom_range(3, 6);
        end else begin
          gap--;
        end
      end
    end
    tests++;
    if (seen !== 30) begin fails++; $display("FAIL rand_count: got %0d lookups expected 30", seen); end
  endtask

  task automatic test_cpu_write_read();
    logic        done, ok;
    logic [7:0]  rd, wdat;
    logic [10:0] waddr;
    int          n1, n2;
    do_rewind(done);
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL rewind_done: got %b expected 1", done); end
    cpu_access(1'b1, 8'hA5, rd, n1, n2, waddr, wdat, ok);
    tests++;
    if ({ok, 8'(n1), 8'(n2), waddr, wdat} !== {1'b1, 8'd1, 8'd0, 11'h000, 8'hA5}) begin
      fails++; $display("FAIL write_a5: got ok=%b we1=%0d we2=%0d addr=%h data=%h expected 1 1 0 000 a5", ok, n1, n2, waddr, wdat);
    end
    cpu_access(1'b1, 8'h5A, rd, n1, n2, waddr, wdat, ok);
    tests++;
    if ({ok, 8'(n1), 8'(n2), waddr, wdat} !== {1'b1, 8'd0, 8'd1, 11'h000, 8'h5A}) begin
      fails++; $display("FAIL write_5a: got ok=%b we1=%0d we2=%0d addr=%h data=%h expected 1 0 1 000 5a", ok, n1, n2, waddr, wdat);
    end
    do_rewind(done);
    cpu_access(1'b0, 8'h00, rd, n1, n2, waddr, wdat, ok);
    tests++;
    if ({ok, rd, 8'(n1 + n2)} !== {1'b1, 8'hA5, 8'd0}) begin
      fails++; $display("FAIL read_a5: got ok=%b dout=%h writes=%0d expected 1 a5 0", ok, rd, n1 + n2);
    end
    cpu_access(1'b0, 8'h00, rd, n1, n2, waddr, wdat, ok);
    tests++;
    if ({ok, rd} !== {1'b1, 8'h5A}) begin
      fails++; $display("FAIL read_5a: got ok=%b dout=%h expected 1 5a", ok, rd);
    end
  endtask

  task automatic test_starvation();
    int          nkv = 0;
    logic        ok = 1'b0;
    logic [11:0] a;
    logic [7:0]  rd = '0, exp;
    a   = exp_cpuaddr;
    exp = exp_cpu_byte(a);
    drive_evt(rand_evt());
    @(negedge clk);
    cpuread = 1'b1;
    drive_evt(rand_evt());
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (key_valid) nkv++;
      if (cpu_done) begin
        ok = 1'b1;
        rd = dout;
      end else begin
        drive_evt(rand_evt());
      end
    end
    cpuread = 1'b0;
    scan_received = 1'b0;
    @(negedge clk);
    if (ok) exp_cpuaddr = exp_cpuaddr + 12'd1;
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL starve_timeout: got no cpu_done expected cpu_done"); end
    tests++;
    if (nkv !== MAXB) begin fails++; $display("FAIL starve_burst: got %0d lookups expected %0d", nkv, MAXB); end
    tests++;
    if (rd !== exp) begin fails++; $display("FAIL starve_dout: got %h expected %h", rd, exp); end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_fifo_drop();
    evt_t        ev [6];
    logic        done, ok = 1'b0, kv_stall = 1'b0;
    logic [7:0]  rd = '0, exp;
    int          seen = 0;
    do_rewind(done);
    exp = exp_cpu_byte(exp_cpuaddr);
    cpuread = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cpu_done) begin ok = 1'b1; rd = dout; end
    end
    tests++;
    if ({ok, rd} !== {1'b1, exp}) begin fails++; $display("FAIL stall_read: got ok=%b dout=%h expected 1 %h", ok, rd, exp); end
    for (int k = 0; k < 6; k++) begin
      ev[k] = rand_evt();
      drive_evt(ev[k]);
      @(negedge clk);
      kv_stall |= key_valid;
    end
    scan_received = 1'b0;
    tests++;
    if ({fifo_full, kv_stall} !== 2'b10) begin
      fails++; $display("FAIL drop_full: got full=%b kv=%b expected 1 0", fifo_full, kv_stall);
    end
`ifdef KMARB_DROP_COUNT_EN
    tests++;
    if (drop_count !== 8'd2) begin fails++; $display("FAIL drop_count: got %0d expected 2", drop_count); end
`endif
    cpuread = 1'b0;
    exp_cpuaddr = exp_cpuaddr + 12'd1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (key_valid) begin
        tests++;
        if (seen >= 4) begin
          fails++; $display("FAIL drop_extra: got lookup %0d expected only 4", seen + 1);
        end else if (got_key() !== exp_key(ev[seen])) begin
          fails++; $display("FAIL drop_key: got %h expected %h", got_key(), exp_key(ev[seen]));
        end
        seen++;
      end
    end
    tests++;
    if ({8'(seen), fifo_full} !== {8'd4, 1'b0}) begin
      fails++; $display("FAIL drop_drain: got %0d lookups full=%b expected 4 0", seen, fifo_full);
    end
  endtask

  task automatic test_wrap();
    logic        done, ok, all_ok = 1'b1;
    logic [7:0]  rd, wdat, exp;
    logic [10:0] waddr;
    int          n1, n2, bad = 0;
    do_rewind(done);
    for (int i = 0; i < 4095; i++) begin
      exp = exp_cpu_byte(exp_cpuaddr);
      cpu_access(1'b0, 8'h00, rd, n1, n2, waddr, wdat, ok);
      all_ok &= ok;
      if (rd !== exp || (n1 + n2) != 0) bad++;
    end
    tests++;
    if ({all_ok, 16'(bad)} !== {1'b1, 16'd0}) begin
      fails++; $display("FAIL wrap_reads: got ok=%b bad=%0d expected 1 0", all_ok, bad);
    end
    cpu_access(1'b1, 8'h3C, rd, n1, n2, waddr, wdat, ok);
    tests++;
    if ({ok, 8'(n1), 8'(n2), waddr} !== {1'b1, 8'd0, 8'd1, 11'h7FF}) begin
      fails++; $display("FAIL wrap_fff: got ok=%b we1=%0d we2=%0d addr=%h expected 1 0 1 7ff", ok, n1, n2, waddr);
    end
    cpu_access(1'b1, 8'hC3, rd, n1, n2, waddr, wdat, ok);
    tests++;
    if ({ok, 8'(n1), 8'(n2), waddr} !== {1'b1, 8'd1, 8'd0, 11'h000}) begin
      fails++; $display("FAIL wrap_000: got ok=%b we1=%0d we2=%0d addr=%h expected 1 1 0 000", ok, n1, n2, waddr);
    end
  endtask

  task automatic test_reset_mid_op();
    logic kv = 1'b0;
    drive_evt(rand_evt());
    @(negedge clk);
    drive_evt(rand_evt());
    @(negedge clk);
    scan_received = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({key_valid, key_released, keyrow1, keycol1, keyrow2, keycol2, dout, cpu_done,
         ram_addr, ram_we1, ram_we2, ram_wdata, fifo_full} !== 49'd0) begin
      fails++;
      $display("FAIL midop_reset: got non-zero outputs, ram_addr=%h dout=%h", ram_addr, dout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cpuaddr = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      kv |= key_valid;
    end
    tests++;
    if ({kv, fifo_full} !== 2'b00) begin
      fails++; $display("FAIL midop_after: got key_valid=%b full=%b expected 0 0", kv, fifo_full);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    scan_received = 1'b0; scan = '0; extended = 1'b0; released = 1'b0; modifiers = '0;
    cpuread = 1'b0; cpuwrite = 1'b0; rewind = 1'b0; din = '0;
    for (int i = 0; i < 2048; i++) begin
      km1[i] = 8'($urandom);
      km2[i] = 8'($urandom);
    end
    test_reset();
    test_single_event();
    test_back_to_back();
    test_random_lookups();
    test_cpu_write_read();
    test_starvation();
    test_fifo_drop();
    test_wrap();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
